// File: rtl/mem_requester.sv
// mem_requester: initiator side of the select/op/valid/rw memory handshake.
// Accepts one host read/write command at a time, presents it to the memory
// controller, waits for valid (bounded by a timeout watchdog) and returns a
// one-cycle response strobe to the host.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata host command channel (ready only in IDLE)
//   rsp_valid/rdata/error           host response (rdata held between strobes)
//   select/op/mem_addr/mem_wdata    request toward controller, frozen in REQ
//   mem_rdata, valid, rw            controller/array return path
module mem_requester #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              select,
  output logic              op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              valid,
  input  logic              rw
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                select_d, op_d, rsp_valid_d, rsp_error_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d, rsp_rdata_d;

  // Ready is a pure decode of the state register.
  assign cmd_ready = (state == IDLE);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      select    <= 1'b0;
      op        <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      select    <= select_d;
      op        <= op_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_error <= rsp_error_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    select_d    = select;
    op_d        = op;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = rsp_rdata;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_write;
          mem_addr_d  = cmd_addr;
          mem_wdata_d = cmd_wdata;
          select_d    = 1'b1;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt + CNT_W'(1);
        // valid takes priority over an expiring watchdog in the same cycle
        if (valid) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = (rw != op);
          select_d    = 1'b0;
          if (!op) rsp_rdata_d = mem_rdata;
          state_d     = RELEASE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          select_d    = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        // wait for the controller to drop valid so select idles >= 1 cycle
        select_d = 1'b0;
        if (!valid) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        select_d = 1'b0;
      end
    endcase
  end

endmodule
